// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant owner, counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_e;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing one memory access; zero_o flags the final busy cycle.
module mem_lat_counter
   import mem_arb_pkg::*;
#(
   parameter int W = CNT_W
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency memory between fetch (I) and MEM-stage (D) accesses, D-first
// with alternation; each access takes MEM_LAT busy cycles plus one done cycle, requesters stall meanwhile.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              proto_err
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   state_e            state_q, state_d;
   grant_e            last_q, last_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic              d_store_q, d_store_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;
   logic              proto_err_q, proto_err_d;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic              i_pend, d_pend;

   // A side whose done is high this cycle still shows its old request; ignore it.
   assign i_pend = if_req & ~if_done_q;
   assign d_pend = (d_rd | d_wr) & ~d_done_q;

   mem_lat_counter #(
      .W (CNT_W)
   ) u_lat_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .val_i  (LAT_LOAD),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      mem_en_d    = 1'b0;
      mem_wr_d    = 1'b0;
      d_store_d   = d_store_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      proto_err_d = proto_err_q | (d_rd & d_wr);
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_pend && ((last_q == GNT_I) || !i_pend)) begin
               state_d     = DBUSY;
               last_d      = GNT_D;
               mem_en_d    = 1'b1;
               mem_wr_d    = d_wr;
               d_store_d   = d_wr;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               cnt_load    = 1'b1;
            end else if (i_pend) begin
               state_d    = IBUSY;
               last_d     = GNT_I;
               mem_en_d   = 1'b1;
               mem_addr_d = if_addr;
               cnt_load   = 1'b1;
            end
         end
         IBUSY: begin
            if (cnt_zero) begin
               if_rdata_d = mem_rdata;
               if_done_d  = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DBUSY: begin
            if (cnt_zero) begin
               if (!d_store_q) begin
                  d_rdata_d = mem_rdata;
               end
               d_done_d = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= GNT_I;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         d_store_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         d_store_q   <= d_store_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_done   = if_done_q;
   assign if_stall  = if_req & ~if_done_q;
   assign d_rdata   = d_rdata_q;
   assign d_done    = d_done_q;
   assign d_stall   = (d_rd | d_wr) & ~d_done_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboarded bench for unified_mem_arbiter with a MEM_LAT=4 memory model (unwritten reads return ~addr).
module tb_unified_mem_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, d_rd, d_wr;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          if_done, if_stall, d_done, d_stall;
   logic          mem_en, mem_wr, proto_err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   unified_mem_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .MEM_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .if_stall  (if_stall),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .d_stall   (d_stall),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .proto_err (proto_err)
   );

   // Memory model: data is only valid in the LAT-th cycle counted from the mem_en cycle.
   logic [DW-1:0] mem_arr [logic [AW-1:0]];
   int            lat_cnt = 0;

   always @(posedge clk) begin
      if (mem_en) begin
         lat_cnt <= 1;
         if (mem_wr) mem_arr[mem_addr] = mem_wdata;
      end else if (lat_cnt != 0 && lat_cnt < LAT) begin
         lat_cnt <= lat_cnt + 1;
      end else begin
         lat_cnt <= 0;
      end
   end

   always @* begin
      if (lat_cnt == LAT - 1)
         mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : ~mem_addr;
      else
         mem_rdata = 16'h0BAD;
   end

   typedef struct {
      bit            side_d;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sbq[$];
   exp_t          e;
   int            total = 0;
   int            bad   = 0;
   int            en_cnt = 0;
   int            wr_cnt = 0;
   logic [DW-1:0] d_last_exp;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mem_en) en_cnt++;
      if (mem_en && mem_wr) wr_cnt++;
      if (if_done || d_done) begin
         if (sbq.size() == 0) begin
            check_eq("sb_unexpected_done", 32'(sbq.size()), 32'd1);
         end else begin
            e = sbq.pop_front();
            check_eq("done_side_d", 32'(d_done), 32'(e.side_d));
            check_eq("done_side_i", 32'(if_done), 32'(!e.side_d));
            check_eq("rdata", 32'(e.side_d ? d_rdata : if_rdata), 32'(e.data));
         end
      end
   end

   task automatic push(input bit side_d, input logic [DW-1:0] data);
      exp_t x;
      x.side_d = side_d;
      x.data   = data;
      sbq.push_back(x);
   endtask

   // Holds requests until n done pulses are seen, then drops everything.
   task automatic drain(input int n, input int budget, input bit chk_gap,
                        output int first_lat, output int stall_cyc);
      int k = 0;
      int it = 0;
      int last = -1;
      first_lat = -1;
      stall_cyc = 0;
      #1;
      if (if_stall) stall_cyc++;
      while (k < n && it < budget) begin
         @(negedge clk);
         it++;
         if (if_stall) stall_cyc++;
         if (if_done || d_done) begin
            k++;
            if (first_lat < 0) first_lat = it;
            if (chk_gap && last >= 0) check_eq("done_gap", 32'(it - last), 32'(LAT + 1));
            last = it;
         end
      end
      if (k < n) check_eq("drain_timeout", 32'(k), 32'(n));
      if_req = 1'b0;
      d_rd   = 1'b0;
      d_wr   = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, stl, e0, w0, dn;
      rst = 1'b1; if_req = 1'b1; d_rd = 1'b1; d_wr = 1'b0;
      if_addr = 16'h0040; d_addr = 16'h0080; d_wdata = '0;

      // Reset with requests active
      repeat (3) begin
         @(negedge clk);
         check_eq("rst_mem_en", 32'(mem_en), 32'd0);
         check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
         check_eq("rst_done", 32'({if_done, d_done}), 32'd0);
         check_eq("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
         check_eq("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
         check_eq("rst_proto", 32'(proto_err), 32'd0);
      end
      push(1'b1, ~16'h0080);
      push(1'b0, ~16'h0040);
      d_last_exp = ~16'h0080;
      rst = 1'b0;
      @(negedge clk);
      check_eq("first_grant_en", 32'(mem_en), 32'd1);
      check_eq("first_grant_addr", 32'(mem_addr), 32'h0080);
      drain(2, 40, 1'b0, lat, stl);

      // Lone fetch
      e0 = en_cnt; w0 = wr_cnt;
      if_addr = 16'h0010; if_req = 1'b1;
      push(1'b0, 16'hFFEF);
      drain(1, 30, 1'b0, lat, stl);
      check_eq("fetch_latency", 32'(lat), 32'd5);
      check_eq("fetch_stall_cycles", 32'(stl), 32'd5);
      check_eq("fetch_en_count", 32'(en_cnt - e0), 32'd1);
      check_eq("fetch_no_write", 32'(wr_cnt - w0), 32'd0);

      // Continuous I and D demand: D,I,D,I
      e0 = en_cnt;
      if_addr = 16'h0020; d_addr = 16'h0030; if_req = 1'b1; d_rd = 1'b1;
      push(1'b1, ~16'h0030); push(1'b0, ~16'h0020);
      push(1'b1, ~16'h0030); push(1'b0, ~16'h0020);
      d_last_exp = ~16'h0030;
      drain(4, 60, 1'b1, lat, stl);
      check_eq("alt_en_count", 32'(en_cnt - e0), 32'd4);

      // Store then load back
      w0 = wr_cnt;
      d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
      push(1'b1, d_last_exp);
      drain(1, 30, 1'b0, lat, stl);
      check_eq("store_wr_count", 32'(wr_cnt - w0), 32'd1);
      d_rd = 1'b1; d_addr = 16'h0100; d_wdata = 16'h0000;
      push(1'b1, 16'hBEEF);
      d_last_exp = 16'hBEEF;
      drain(1, 30, 1'b0, lat, stl);
      check_eq("load_no_write", 32'(wr_cnt - w0), 32'd1);

      // Last grant was D: simultaneous demand goes to I first
      if_addr = 16'h0050; d_addr = 16'h0060; if_req = 1'b1; d_rd = 1'b1;
      push(1'b0, ~16'h0050); push(1'b1, ~16'h0060);
      d_last_exp = ~16'h0060;
      drain(2, 40, 1'b0, lat, stl);

      // Reset in the middle of a D access
      e0 = en_cnt;
      d_rd = 1'b1; d_addr = 16'h0070;
      repeat (2) @(negedge clk);
      rst = 1'b1; d_rd = 1'b0;
      @(negedge clk);
      check_eq("abort_mem_en", 32'(mem_en), 32'd0);
      check_eq("abort_d_rdata", 32'(d_rdata), 32'd0);
      rst = 1'b0;
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (d_done) dn++;
      end
      check_eq("abort_no_done", 32'(dn), 32'd0);
      check_eq("abort_en_count", 32'(en_cnt - e0), 32'd1);
      d_last_exp = 16'h0000;
      d_rd = 1'b1; d_addr = 16'h0071;
      push(1'b1, ~16'h0071);
      d_last_exp = ~16'h0071;
      @(negedge clk);
      check_eq("post_abort_grant", 32'(mem_en), 32'd1);
      drain(1, 30, 1'b0, lat, stl);

      // d_rd & d_wr together
      w0 = wr_cnt;
      d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
      push(1'b1, d_last_exp);
      drain(1, 30, 1'b0, lat, stl);
      check_eq("both_is_store", 32'(wr_cnt - w0), 32'd1);
      check_eq("proto_err_set", 32'(proto_err), 32'd1);
      d_rd = 1'b1; d_addr = 16'h0200; d_wdata = 16'h0000;
      push(1'b1, 16'h1234);
      drain(1, 30, 1'b0, lat, stl);
      check_eq("proto_err_sticky", 32'(proto_err), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("proto_err_cleared", 32'(proto_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      check_eq("sb_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
